// File: rtl/err_ctrl_pkg.sv
// Shared types and the lane-patch helper for the error-detecting stage controller.
package err_ctrl_pkg;

  typedef enum logic [1:0] {EMPTY, CHECK, REPLAY, FULL} state_t;
  typedef enum logic {FAST, SAFE} mode_t;

  // Widest token the patch helper handles; callers zero-extend into it.
  localparam int unsigned PATCH_MAX_W = 256;

  function automatic logic [PATCH_MAX_W-1:0] lane_patch(
    input logic [PATCH_MAX_W-1:0] token,
    input logic [PATCH_MAX_W-1:0] shd,
    input logic [PATCH_MAX_W-1:0] err,
    input int unsigned            lane_w
  );
    logic [PATCH_MAX_W-1:0] res;
    logic [7:0]             lane;
    res = token;
    for (int b = 0; b < PATCH_MAX_W; b++) begin
      lane = 8'(int'(b) / int'(lane_w));
      if (err[lane]) res[b] = shd[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/err_mode_tracker.sv
// FAST/SAFE check-mode selection from the recent history of error events and clean transfers.
module err_mode_tracker
  import err_ctrl_pkg::*;
#(
  parameter int unsigned ERR_THRESH  = 2,
  parameter int unsigned QUIET_XFERS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ev_err,
  input  logic ev_clean,
  output logic mode
);

  localparam int unsigned SW = $clog2(ERR_THRESH + 1);
  localparam int unsigned QW = $clog2(QUIET_XFERS + 1);

  mode_t          mode_q, mode_d;
  logic [SW-1:0]  streak_q, streak_d;
  logic [QW-1:0]  quiet_q, quiet_d;

  always_comb begin
    mode_d   = mode_q;
    streak_d = streak_q;
    quiet_d  = quiet_q;
    if (ev_err) begin
      quiet_d = '0;
      if (mode_q == FAST && streak_q == SW'(ERR_THRESH - 1)) begin
        mode_d   = SAFE;
        streak_d = '0;
      end else if (streak_q != SW'(ERR_THRESH)) begin
        // streak keeps counting in SAFE but is held below wrap-around
        streak_d = streak_q + 1'b1;
      end
    end else if (ev_clean) begin
      if (quiet_q == QW'(QUIET_XFERS - 1)) begin
        quiet_d  = '0;
        streak_d = '0;
        mode_d   = FAST;
      end else begin
        quiet_d = quiet_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= FAST;
      streak_q <= '0;
      quiet_q  <= '0;
    end else begin
      mode_q   <= mode_d;
      streak_q <= streak_d;
      quiet_q  <= quiet_d;
    end
  end

  assign mode = (mode_q == SAFE);

endmodule

// File: rtl/err_stage_ctrl.sv
// Pipeline stage controller: captures a token, checks it, patches flagged lanes, replays, forwards.
//   state  | meaning
//   EMPTY  | ready for a token, Lack high
//   CHECK  | sample pulsed, error flags read on the last cycle
//   REPLAY | stall after a patched token
//   FULL   | token offered on the right, Rreq high
module err_stage_ctrl
  import err_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned N_LANES       = 4,
  parameter int unsigned REPLAY_CYCLES = 2,
  parameter int unsigned ERR_THRESH    = 2,
  parameter int unsigned QUIET_XFERS   = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Lreq,
  output logic               Lack,
  input  logic [DATA_W-1:0]  Ldata,
  output logic               Rreq,
  input  logic               Rack,
  output logic [DATA_W-1:0]  Rdata,
  output logic               sample,
  input  logic [N_LANES-1:0] Err,
  input  logic [DATA_W-1:0]  Shd,
  output logic               mode,
  output logic [CNT_W-1:0]   err_count
);

  localparam int unsigned LANE_W = DATA_W / N_LANES;
  localparam int unsigned RW     = $clog2(REPLAY_CYCLES + 1);

  if (DATA_W % N_LANES != 0 || DATA_W > PATCH_MAX_W) begin : g_bad_width
    $error("err_stage_ctrl: DATA_W must be a multiple of N_LANES and fit the patch helper");
  end

  state_t                 state_q, state_d;
  logic [DATA_W-1:0]      token_q;
  logic                   two_chk_q;
  logic                   chk_second_q;
  logic [RW-1:0]          rep_q;
  logic [CNT_W-1:0]       err_cnt_q;
  logic                   chk_last, ev_err, ev_clean;
  logic [PATCH_MAX_W-1:0] tok_ext, shd_ext, err_ext, patched;
  logic                   unused_patch;

  always_comb begin
    tok_ext = '0;
    shd_ext = '0;
    err_ext = '0;
    tok_ext[DATA_W-1:0]  = token_q;
    shd_ext[DATA_W-1:0]  = Shd;
    err_ext[N_LANES-1:0] = Err;
    patched = lane_patch(tok_ext, shd_ext, err_ext, LANE_W);
  end
  assign unused_patch = ^patched;

  assign chk_last = (state_q == CHECK) && (!two_chk_q || chk_second_q);
  assign ev_err   = chk_last && (|Err);
  assign ev_clean = chk_last && !(|Err);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (Lreq) state_d = CHECK;
      CHECK:   if (chk_last) state_d = (|Err) ? REPLAY : FULL;
      REPLAY:  if (rep_q == RW'(1)) state_d = FULL;
      FULL:    if (Rack) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      token_q      <= '0;
      two_chk_q    <= 1'b0;
      chk_second_q <= 1'b0;
      rep_q        <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        EMPTY: if (Lreq) begin
          token_q      <= Ldata;
          two_chk_q    <= mode;
          chk_second_q <= 1'b0;
        end
        CHECK: begin
          chk_second_q <= 1'b1;
          if (ev_err) begin
            token_q <= patched[DATA_W-1:0];
            rep_q   <= RW'(REPLAY_CYCLES);
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
          end
        end
        REPLAY:  rep_q <= rep_q - 1'b1;
        default: ;
      endcase
    end
  end

  err_mode_tracker #(
    .ERR_THRESH (ERR_THRESH),
    .QUIET_XFERS(QUIET_XFERS)
  ) u_mode (
    .clk     (clk),
    .rst     (rst),
    .ev_err  (ev_err),
    .ev_clean(ev_clean),
    .mode    (mode)
  );

  assign Lack      = (state_q == EMPTY);
  assign Rreq      = (state_q == FULL);
  assign sample    = (state_q == CHECK);
  assign Rdata     = token_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_err_stage_ctrl.sv
// Directed bench for err_stage_ctrl; a CNT_W=2 copy shares the stimulus to cover counter saturation.
module tb_err_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst, Lreq, Rack;
  logic [31:0] Ldata, Shd;
  logic [3:0]  Err;
  logic        Lack, Rreq, sample, mode;
  logic [31:0] Rdata;
  logic [7:0]  err_count;
  logic        sat_unused_lack, sat_unused_rreq, sat_unused_sample, sat_unused_mode;
  logic [31:0] sat_unused_rdata;
  logic [1:0]  sat_count;

  always #5 clk = ~clk;

  err_stage_ctrl u_dut (
    .clk(clk), .rst(rst), .Lreq(Lreq), .Lack(Lack), .Ldata(Ldata), .Rreq(Rreq),
    .Rack(Rack), .Rdata(Rdata), .sample(sample), .Err(Err), .Shd(Shd),
    .mode(mode), .err_count(err_count)
  );

  err_stage_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .Lreq(Lreq), .Lack(sat_unused_lack), .Ldata(Ldata),
    .Rreq(sat_unused_rreq), .Rack(Rack), .Rdata(sat_unused_rdata),
    .sample(sat_unused_sample), .Err(Err), .Shd(Shd), .mode(sat_unused_mode),
    .err_count(sat_count)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; Lreq = 1'b0; Rack = 1'b1; Err = '0; Shd = '0; Ldata = '0;
    tick; tick;
    rst = 1'b0;
  endtask

  logic        lack_cap;
  int          scnt, rreq_at;
  logic [31:0] rd;

  // One full transfer with Rack held high; rreq_at counts cycles from the capture edge t0.
  task automatic xfer(input logic [31:0] d, input logic [3:0] e, input logic [31:0] s);
    int n;
    Lreq = 1'b1; Ldata = d; Err = e; Shd = s; Rack = 1'b1;
    tick;
    Lreq = 1'b0;
    lack_cap = Lack;
    scnt = 0;
    n = 0;
    while (!Rreq && n < 40) begin
      if (sample) scnt++;
      tick;
      n++;
    end
    if (n >= 40) chk("rreq_timeout", 32'(Rreq), 32'd1);
    rreq_at = n + 1;
    rd = Rdata;
    Err = '0;
    tick;
  endtask

  int   n;
  logic stable;

  initial begin
    do_reset;
    chk("rst_lack", 32'(Lack), 32'd1);
    chk("rst_rreq", 32'(Rreq), 32'd0);
    chk("rst_rdata", Rdata, 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);

    // clean FAST transfer
    xfer(32'hA5A5A5A5, 4'b0000, 32'h0);
    chk("t1_lack_fall", 32'(lack_cap), 32'd0);
    chk("t1_sample_len", 32'(scnt), 32'd1);
    chk("t1_rreq_at", 32'(rreq_at), 32'd2);
    chk("t1_rdata", rd, 32'hA5A5A5A5);
    chk("t1_errcnt", 32'(err_count), 32'd0);

    // lane 2 flagged and patched from shadow
    xfer(32'h11223344, 4'b0100, 32'hFFFFFFFF);
    chk("t2_rdata", rd, 32'h11FF3344);
    chk("t2_rreq_at", 32'(rreq_at), 32'd4);
    chk("t2_sample_len", 32'(scnt), 32'd1);
    chk("t2_errcnt", 32'(err_count), 32'd1);

    // FAST -> SAFE -> FAST
    do_reset;
    xfer(32'h00000001, 4'b0001, 32'h00000000);
    chk("t3_mode_after_err1", 32'(mode), 32'd0);
    xfer(32'h00000002, 4'b0010, 32'h00000000);
    chk("t3_mode_after_err2", 32'(mode), 32'd1);
    chk("t3_errcnt", 32'(err_count), 32'd2);
    xfer(32'h0000BEEF, 4'b0000, 32'h0);
    chk("t3_safe_sample_len", 32'(scnt), 32'd2);
    chk("t3_safe_rreq_at", 32'(rreq_at), 32'd3);
    chk("t3_safe_rdata", rd, 32'h0000BEEF);
    xfer(32'h1, 4'b0000, 32'h0);
    xfer(32'h2, 4'b0000, 32'h0);
    chk("t3_mode_after_3_clean", 32'(mode), 32'd1);
    xfer(32'h3, 4'b0000, 32'h0);
    chk("t3_mode_after_4_clean", 32'(mode), 32'd0);
    xfer(32'h4, 4'b0000, 32'h0);
    chk("t3_fast_sample_len", 32'(scnt), 32'd1);
    chk("t3_fast_rreq_at", 32'(rreq_at), 32'd2);

    // back-pressure: Rack low for 10 cycles in FULL, Lreq kept high
    Lreq = 1'b1; Ldata = 32'hCAFEF00D; Err = '0; Rack = 1'b0;
    tick;
    Ldata = 32'hDEAD0000;
    n = 0;
    while (!Rreq && n < 40) begin
      tick;
      n++;
    end
    if (n >= 40) chk("t4_rreq_timeout", 32'(Rreq), 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!Rreq || Rdata !== 32'hCAFEF00D || Lack) stable = 1'b0;
      tick;
    end
    chk("t4_hold_stable", 32'(stable), 32'd1);
    Lreq = 1'b0; Rack = 1'b1;
    tick;
    chk("t4_release_lack", 32'(Lack), 32'd1);
    chk("t4_release_rreq", 32'(Rreq), 32'd0);
    chk("t4_lreq_ignored", Rdata, 32'hCAFEF00D);

    // reset in REPLAY; first build up SAFE mode and a non-zero count
    xfer(32'h00000000, 4'b0010, 32'hFFFFFFFF);
    chk("t5_pre_rdata", rd, 32'h0000FF00);
    Lreq = 1'b1; Ldata = 32'h12345678; Err = 4'b0001; Shd = '0;
    tick;
    Lreq = 1'b0;
    tick;
    chk("t5_replay_sample", 32'(sample), 32'd0);
    chk("t5_replay_rreq", 32'(Rreq), 32'd0);
    chk("t5_replay_lack", 32'(Lack), 32'd0);
    chk("t5_replay_mode", 32'(mode), 32'd1);
    chk("t5_replay_errcnt", 32'(err_count), 32'd4);
    rst = 1'b1; Err = '0;
    tick;
    rst = 1'b0;
    chk("t5_post_lack", 32'(Lack), 32'd1);
    chk("t5_post_rreq", 32'(Rreq), 32'd0);
    chk("t5_post_errcnt", 32'(err_count), 32'd0);
    chk("t5_post_mode", 32'(mode), 32'd0);
    chk("t5_post_rdata", Rdata, 32'd0);

    // saturation of the 2-bit counter
    do_reset;
    for (int k = 1; k <= 5; k++) begin
      xfer(32'(k), 4'b1000, 32'hAB000000);
      chk("t6_sat_count", 32'(sat_count), (k > 3) ? 32'd3 : 32'(k));
    end
    chk("t6_wide_count", 32'(err_count), 32'd5);
    chk("t6_last_rdata", rd, 32'hAB000005);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/err_stage_ctrl.md
# err_stage_ctrl

Clocked, parametrised successor to the error-detecting pipeline stage controller. Holds one `DATA_W`-bit token split into `N_LANES` lanes and moves it between a left and a right req/ack handshake. It pulses `sample` so the downstream error detectors check the token, and patches any flagged lane from the shadow data. It replays (stalls) before forwarding, and switches between FAST and SAFE check modes based on the recent error history.

## Interface
- `DATA_W`, 32: token width; must be divisible by `N_LANES`.
- `N_LANES`, 4: error-detection lanes; `LANE_W = DATA_W/N_LANES`.
- `REPLAY_CYCLES`, 2: stall cycles after an error (≥1).
- `ERR_THRESH`, 2: error events that switch FAST→SAFE (≥1).
- `QUIET_XFERS`, 4: consecutive clean transfers that clear the streak (FAST) or return to FAST (SAFE).
- `CNT_W`, 8: width of the saturating error counter.
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `Lreq`  in  1  left request; token valid on `Ldata`.
- `Lack`  out  1  left acknowledge; high only in EMPTY.
- `Ldata`  in  DATA_W  incoming token.
- `Rreq`  out  1  right request; high only in FULL.
- `Rack`  in  1  right acknowledge.
- `Rdata`  out  DATA_W  held token.
- `sample`  out  1  high in every CHECK cycle.
- `Err`  in  N_LANES  per-lane error flags; sampled in the last CHECK cycle.
- `Shd`  in  DATA_W  shadow (late-sampled) data; sampled together with `Err`.
- `mode`  out  1  0=FAST, 1=SAFE.
- `err_count`  out  CNT_W  total error events, saturating.

## Operation
- States: EMPTY, CHECK, REPLAY, FULL.
- EMPTY:
  - `Lack`=1.
  - When `Lreq`=1, `Ldata` is registered and the state moves to CHECK.
  - The CHECK length is latched from `mode` at this edge: 1 cycle in FAST, 2 in SAFE.
- CHECK:
  - `sample`=1 and `Lack`=0.
  - On the last CHECK cycle, if `|Err`=1:
    - each lane i with `Err[i]`=1 is replaced by `Shd[i*LANE_W +: LANE_W]`;
    - `err_count` increments unless it is already at `2^CNT_W-1`;
    - the replay counter loads `REPLAY_CYCLES`;
    - the state moves to REPLAY.
  - Otherwise the state moves to FULL.
  - `Err` is ignored on a non-last CHECK cycle.
- REPLAY:
  - The counter decrements each cycle; the state moves to FULL on the cycle it reads 1.
  - `Err` is ignored.
- FULL:
  - `Rreq`=1 and `Rdata`=token.
  - When `Rack`=1, the state moves to EMPTY.
  - `Lack` stays 0 in FULL; a transfer needs at least one EMPTY cycle.
- Mode tracking is updated once per CHECK outcome.
  - Error event: streak+1 and quiet:=0.
    - In FAST, if streak reaches `ERR_THRESH`, then mode:=SAFE and streak:=0.
  - Clean transfer: quiet+1.
    - When quiet reaches `QUIET_XFERS`: in FAST, streak:=0; in SAFE, mode:=FAST and streak:=0.
    - In both cases quiet:=0.
  - A mode change affects only the next capture, never the token currently in CHECK.
- Reset: state EMPTY, token discarded, all counters 0, mode FAST. It wins over any handshake in the same cycle, including mid-CHECK or mid-REPLAY.

## Timing
- Reset values: `Lack`=1 (EMPTY), `Rreq`=0, `Rdata`=0, `sample`=0, `mode`=0, `err_count`=0.
- Capture edge is t0.
  - FAST, clean: `sample` in cycle t0+1, `Rreq` from t0+2.
  - FAST, error: `sample` at t0+1, REPLAY in t0+2..t0+1+R, `Rreq` from t0+2+R.
  - SAFE adds one cycle to each case.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- `Rreq` holds and `Rdata` stays stable until the `Rack` edge. `Lack` falls on the cycle after the capture edge.
- Minimum period is 3 cycles per token (FAST, clean, `Rack` held high).

## Structure
- Package `err_ctrl_pkg` holds:
  - `state_t` enum {EMPTY, CHECK, REPLAY, FULL};
  - `mode_t` enum {FAST, SAFE};
  - the function `lane_patch(token, shd, err)`.
- Sub-module `err_mode_tracker` holds the streak and quiet counters and the mode register. Its inputs are `rst`, `ev_err`, `ev_clean`; its output is `mode`. Main FSM, token register and `err_count` stay in `err_stage_ctrl`.
- Elaboration check: `DATA_W % N_LANES == 0`.

## Test plan
1. Reset, then `Lreq`=1 with `Ldata`=0xA5A5A5A5, `Err`=0, `Rack` held 1:
   - `Lack` falls at t0+1, `sample`=1 at t0+1;
   - `Rreq`=1 at t0+2 with `Rdata`=0xA5A5A5A5;
   - `err_count`=0.
2. `Ldata`=0x11223344, `Err`=4'b0100 and `Shd`=0xFFFFFFFF during CHECK:
   - `Rdata`=0x11FF3344;
   - `Rreq` rises at t0+4 (R=2);
   - `err_count`=1.
3. Two consecutive error transfers:
   - `mode`=1 after the second;
   - the next token shows `sample` high for 2 cycles and `Rreq` at t0+3.
   - Then 4 clean transfers: `mode`=0, and the following token shows a 1-cycle `sample`.
4. `Rack` held 0 for 10 cycles in FULL:
   - `Rreq` and `Rdata` stay stable;
   - `Lack`=0 throughout, so `Lreq` is ignored.
5. Assert `rst` during the REPLAY cycle:
   - next cycle the state is EMPTY: `Lack`=1, `Rreq`=0;
   - `err_count`=0 and `mode`=0.
6. `CNT_W`=2 with 5 error events: `err_count` saturates at 3.
